// File: rtl/sync_debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and constants for the sync_debounce input conditioner.
//   - db_state_t : debounce FSM state encoding.
//   - GLITCH_W   : width of the optional rejected-transition counter.
//   - stable_state() : maps a level to the FSM state that holds it.
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } db_state_t;

    localparam int GLITCH_W = 16;

    function automatic db_state_t stable_state(input logic lvl);
        return lvl ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

// File: rtl/sync_debounce_if.sv
// -----------------------------------------------------------------------------
// sync_debounce_if
//   Signal bundle between a debounce block and its user.
//   master : drives din_async, tick (and glitch_clr); observes level/rise/fall.
//   slave  : the debounce block itself.
//   With DEBOUNCE_STATS_EN defined the bundle also carries glitch_cnt and
//   glitch_clr.
// -----------------------------------------------------------------------------
interface sync_debounce_if;
    import debounce_pkg::*;

    logic din_async;  // raw asynchronous input
    logic tick;       // sample qualifier
    logic level;      // debounced level
    logic rise;       // one-clk pulse on accepted 0->1
    logic fall;       // one-clk pulse on accepted 1->0

`ifdef DEBOUNCE_STATS_EN
    logic [GLITCH_W-1:0] glitch_cnt;  // rejected transitions, saturating
    logic                glitch_clr;  // synchronous clear of glitch_cnt

    modport master (
        output din_async, tick, glitch_clr,
        input  level, rise, fall, glitch_cnt
    );

    modport slave (
        input  din_async, tick, glitch_clr,
        output level, rise, fall, glitch_cnt
    );
`else
    modport master (
        output din_async, tick,
        input  level, rise, fall
    );

    modport slave (
        input  din_async, tick,
        output level, rise, fall
    );
`endif

endinterface

// File: rtl/sync_debounce_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   N-flop synchronizer with asynchronous active-low reset.
//   Parameters : STAGES  - number of flops (>= 2)
//                RST_VAL - value loaded into every flop while in reset
//   Ports      : clk, rst_n  - clock / async active-low reset
//                d           - asynchronous input
//                q           - synchronized output (last flop)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//   Conditions an asynchronous, bouncy level into a clean clk-synchronous
//   level with single-cycle rise/fall pulses.
//   Chain: sync_chain -> debounce FSM with tick-qualified counter ->
//          registered level + edge pulses.
//
//   Parameters : SYNC_STAGES     - synchronizer depth, 2..4
//                DEBOUNCE_CYCLES - consecutive qualified samples to accept, >= 2
//                RESET_LEVEL     - level held by sync chain / output in reset
//   Ports      : clk, rst_n      - clock / async active-low reset
//                bus (slave)     - din_async, tick in; level, rise, fall out
//
//   Optional feature: define DEBOUNCE_STATS_EN to add the saturating
//   glitch_cnt output and glitch_clr input on the bus.
//
//   Latency with tick held high: level changes SYNC_STAGES+DEBOUNCE_CYCLES+1
//   edges after din_async changes.
// -----------------------------------------------------------------------------
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_debounce_if.slave bus
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam db_state_t        RST_STATE = stable_state(RESET_LEVEL);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("sync_debounce: SYNC_STAGES must be in 2..4");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
            $error("sync_debounce: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Synchronizer: raw_s is the only view of din_async inside this block.
    // -------------------------------------------------------------------------
    logic raw_s;

    sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.din_async),
        .q     (raw_s)
    );

    // -------------------------------------------------------------------------
    // FSM + counter
    // -------------------------------------------------------------------------
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;  // qualification completed this cycle
    logic             abort;   // pending transition rejected this cycle

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic. A reversal is tested before the count so that a
    // reversal arriving on the completing sample always wins.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        abort   = 1'b0;

        // NOTE: combinational blocks use blocking '=' so later statements see
        // the updated value; flops above use '<=' so all update together.
        unique case (state_q)
            STABLE_LO: begin
                if (raw_s) begin
                    state_d = CHK_HI;
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!raw_s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (bus.tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STABLE_HI: begin
                if (!raw_s) begin
                    state_d = CHK_LO;
                    cnt_d   = '0;
                end
            end
            CHK_LO: begin
                if (raw_s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (bus.tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: level and pulses change only on acceptance, and the
    // direction follows the CHK_* state being left.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (accept) begin
            level_d = (state_q == CHK_HI);
            rise_d  = (state_q == CHK_HI);
            fall_d  = (state_q == CHK_LO);
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

    // -------------------------------------------------------------------------
    // Optional rejected-transition statistics
    // -------------------------------------------------------------------------
`ifdef DEBOUNCE_STATS_EN
    logic [GLITCH_W-1:0] glitch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (bus.glitch_clr) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != '1)) begin
            glitch_q <= glitch_q + 1'b1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//   Self-checking bench for sync_debounce (default parameters plus a
//   RESET_LEVEL=1 instance). Table-driven segments, hand-written corner
//   sequences, then randomized stimulus compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

    localparam int SYNC = 2;
    localparam int DB   = 16;
    localparam int LAT  = SYNC + DB + 1;  // 19 edges

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sync_debounce_if if0 ();
    sync_debounce_if if1 ();

    sync_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .RESET_LEVEL     (1'b0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    sync_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .RESET_LEVEL     (1'b1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    // ---------------------------------------------------------------------
    // Bookkeeping
    // ---------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    int rise0_n = 0, fall0_n = 0, rise1_n = 0, fall1_n = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural reference for u_dut0: the input is seen SYNC edges late;
    // a level different from the accepted one must persist through DB
    // tick-qualified samples, and any return to the accepted level first
    // cancels the attempt and counts as a glitch.
    // ---------------------------------------------------------------------
    bit m_pipe [SYNC];
    bit m_s;
    bit m_level, m_pending, m_rise, m_fall;
    int m_ticks;
    int m_glitch;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_pipe[i]) m_pipe[i] = 1'b0;
            m_level   = 1'b0;
            m_pending = 1'b0;
            m_ticks   = 0;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            m_glitch  = 0;
        end else begin
            m_s = m_pipe[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = if0.din_async;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (!m_pending) begin
                if (m_s != m_level) begin
                    m_pending = 1'b1;
                    m_ticks   = 0;
                end
            end else if (m_s == m_level) begin
                m_pending = 1'b0;
                if (m_glitch < 65535) m_glitch++;
            end else if (if0.tick) begin
                m_ticks++;
                if (m_ticks == DB) begin
                    m_level   = m_s;
                    m_pending = 1'b0;
                    m_rise    = m_s;
                    m_fall    = !m_s;
                end
            end
`ifdef DEBOUNCE_STATS_EN
            if (if0.glitch_clr) m_glitch = 0;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Advance n clocks; outputs are sampled on the falling edge.
    // ---------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            rise0_n += int'(if0.rise);
            fall0_n += int'(if0.fall);
            rise1_n += int'(if1.rise);
            fall1_n += int'(if1.fall);
            check("rise_fall_excl0", 32'(if0.rise & if0.fall), 32'd0);
            check("rise_fall_excl1", 32'(if1.rise & if1.fall), 32'd0);
            if (model_on) begin
                check("model_level", 32'(if0.level), 32'(m_level));
                check("model_rise",  32'(if0.rise),  32'(m_rise));
                check("model_fall",  32'(if0.fall),  32'(m_fall));
`ifdef DEBOUNCE_STATS_EN
                check("model_glitch", 32'(if0.glitch_cnt), 32'(m_glitch));
`endif
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        if0.din_async = 1'b0;
        if0.tick      = 1'b1;
        if1.din_async = 1'b1;
        if1.tick      = 1'b1;
`ifdef DEBOUNCE_STATS_EN
        if0.glitch_clr = 1'b0;
        if1.glitch_clr = 1'b0;
`endif
        step(2);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Table of segments applied back to back from reset
    // ---------------------------------------------------------------------
    typedef struct {
        logic din;
        logic tick;
        int   cycles;
        logic exp_level;
        int   exp_rises;
        int   exp_falls;
        int   exp_glitch;  // cumulative since reset
    } vec_t;

    vec_t vecs [14];

    initial begin
        int r0, f0;
        logic cur;

        // Watchdog
        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        vecs[0]  = '{1'b1, 1'b1, 10, 1'b0, 0, 0, 0};  // 10-clk pulse
        vecs[1]  = '{1'b0, 1'b1, 30, 1'b0, 0, 0, 1};  // rejected
        vecs[2]  = '{1'b1, 1'b1, 3,  1'b0, 0, 0, 1};  // bounce train
        vecs[3]  = '{1'b0, 1'b1, 3,  1'b0, 0, 0, 2};
        vecs[4]  = '{1'b1, 1'b1, 3,  1'b0, 0, 0, 2};
        vecs[5]  = '{1'b0, 1'b1, 3,  1'b0, 0, 0, 3};
        vecs[6]  = '{1'b1, 1'b1, 18, 1'b0, 0, 0, 3};  // final toggle, edges 1..18
        vecs[7]  = '{1'b1, 1'b1, 1,  1'b1, 1, 0, 3};  // edge 19: accept
        vecs[8]  = '{1'b1, 1'b1, 5,  1'b1, 0, 0, 3};
        vecs[9]  = '{1'b0, 1'b1, 18, 1'b1, 0, 0, 3};
        vecs[10] = '{1'b0, 1'b1, 1,  1'b0, 0, 1, 3};  // fall on edge 19
        vecs[11] = '{1'b0, 1'b1, 4,  1'b0, 0, 0, 3};
        vecs[12] = '{1'b1, 1'b0, 40, 1'b0, 0, 0, 3};  // no ticks: count holds
        vecs[13] = '{1'b0, 1'b1, 5,  1'b0, 0, 0, 4};  // reversal still aborts

        if0.din_async = 1'b0;
        if0.tick      = 1'b1;
        if1.din_async = 1'b1;
        if1.tick      = 1'b1;
`ifdef DEBOUNCE_STATS_EN
        if0.glitch_clr = 1'b0;
        if1.glitch_clr = 1'b0;
`endif

        // ---- Asynchronous reset before any clock edge ----
        #2 rst_n = 1'b0;
        #1;
        check("rst_level0", 32'(if0.level), 32'd0);
        check("rst_rise0",  32'(if0.rise),  32'd0);
        check("rst_fall0",  32'(if0.fall),  32'd0);
        check("rst_level1", 32'(if1.level), 32'd1);
        check("rst_fall1",  32'(if1.fall),  32'd0);
`ifdef DEBOUNCE_STATS_EN
        check("rst_glitch", 32'(if0.glitch_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // ---- 1: 0->1 held, exact acceptance edge ----
        step(1);
        if0.din_async = 1'b1;
        f0 = fall0_n;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            if (k == LAT - 1) check("t1_level_e18", 32'(if0.level), 32'd0);
            if (k == LAT) begin
                check("t1_level_e19", 32'(if0.level), 32'd1);
                check("t1_rise_e19",  32'(if0.rise),  32'd1);
            end
            if (k == LAT + 1) begin
                check("t1_rise_e20",  32'(if0.rise),  32'd0);
                check("t1_level_e20", 32'(if0.level), 32'd1);
            end
        end
        check("t1_no_fall", 32'(fall0_n - f0), 32'd0);

        // ---- Table: glitch, bounce train, fall, tick hold ----
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if0.din_async = vecs[i].din;
            if0.tick      = vecs[i].tick;
            r0 = rise0_n;
            f0 = fall0_n;
            step(vecs[i].cycles);
            check($sformatf("vec%0d_level", i), 32'(if0.level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d_rises", i), 32'(rise0_n - r0), 32'(vecs[i].exp_rises));
            check($sformatf("vec%0d_falls", i), 32'(fall0_n - f0), 32'(vecs[i].exp_falls));
`ifdef DEBOUNCE_STATS_EN
            check($sformatf("vec%0d_glitch", i), 32'(if0.glitch_cnt), 32'(vecs[i].exp_glitch));
`endif
        end

        // ---- 4: tick every 4th clock, acceptance after 16 ticks ----
        if0.din_async = 1'b1;
        r0 = rise0_n;
        for (int k = 1; k <= 66; k++) begin
            if0.tick = (k % 4 == 0);
            step(1);
            if (k == LAT) check("t4_level_e19", 32'(if0.level), 32'd0);
            if (k == 63)  check("t4_level_e63", 32'(if0.level), 32'd0);
            if (k == 64) begin
                check("t4_level_e64", 32'(if0.level), 32'd1);
                check("t4_rise_e64",  32'(if0.rise),  32'd1);
            end
        end
        check("t4_one_rise", 32'(rise0_n - r0), 32'd1);
        if0.tick = 1'b1;
        step(3);

        // ---- Reversal on the completing sample: no acceptance ----
        f0 = fall0_n;
        if0.din_async = 1'b0;
        step(16);
        if0.din_async = 1'b1;
        step(10);
        check("rev_level", 32'(if0.level), 32'd1);
        check("rev_no_fall", 32'(fall0_n - f0), 32'd0);
`ifdef DEBOUNCE_STATS_EN
        check("rev_glitch", 32'(if0.glitch_cnt), 32'd5);
`endif
        // One more low sample and it is accepted.
        if0.din_async = 1'b0;
        step(17);
        if0.din_async = 1'b1;
        step(10);
        check("rev17_level", 32'(if0.level), 32'd0);
        check("rev17_one_fall", 32'(fall0_n - f0), 32'd1);
`ifdef DEBOUNCE_STATS_EN
        if0.glitch_clr = 1'b1;
        step(1);
        if0.glitch_clr = 1'b0;
        check("glitch_clr", 32'(if0.glitch_cnt), 32'd0);
`endif

        // ---- 5: reset during CHK_HI with count at 10 ----
        do_reset();
        step(1);
        if0.din_async = 1'b1;
        step(13);
        rst_n = 1'b0;
        #1;
        check("t5_rst_level", 32'(if0.level), 32'd0);
        check("t5_rst_rise",  32'(if0.rise),  32'd0);
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step(1);
            if (k == LAT - 1) check("t5_level_e18", 32'(if0.level), 32'd0);
            if (k == LAT) begin
                check("t5_level_e19", 32'(if0.level), 32'd1);
                check("t5_rise_e19",  32'(if0.rise),  32'd1);
            end
        end

        // ---- 6: RESET_LEVEL=1 instance ----
        check("t6_held1_no_rise", 32'(rise1_n), 32'd0);
        check("t6_held1_no_fall", 32'(fall1_n), 32'd0);
        check("t6_level_init", 32'(if1.level), 32'd1);
        if1.din_async = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            if (k == LAT - 1) check("t6_level_e18", 32'(if1.level), 32'd1);
            if (k == LAT) begin
                check("t6_level_e19", 32'(if1.level), 32'd0);
                check("t6_fall_e19",  32'(if1.fall),  32'd1);
            end
            if (k == LAT + 1) check("t6_fall_e20", 32'(if1.fall), 32'd0);
        end
        check("t6_no_rise", 32'(rise1_n), 32'd0);
        // Asynchronous return to the reset level, no clock edge needed.
        rst_n = 1'b0;
        #1;
        check("t6_rst_level1", 32'(if1.level), 32'd1);
        check("t6_rst_level0", 32'(if0.level), 32'd0);

        // ---- Randomized stimulus against the model ----
        do_reset();
        model_on = 1'b1;
        cur = 1'b0;
        for (int seg = 0; seg < 160; seg++) begin
            int  hold;
            bit  tick_rand;
            if ($urandom_range(0, 3) != 0) cur = ~cur;
            hold      = $urandom_range(1, 36);
            tick_rand = ($urandom_range(0, 2) == 0);
            if0.din_async = cur;
            for (int c = 0; c < hold; c++) begin
                if0.tick = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef DEBOUNCE_STATS_EN
                if0.glitch_clr = ($urandom_range(0, 59) == 0);
`endif
                step(1);
            end
        end
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
